pin_entry_frontend: RTL and testbench

- Operator-side front end that drives the safe's PIN/push input interface.
- Synchronises and debounces the raw board buttons, and captures the 4-bit PIN switches at each accepted press.
- Emits single-cycle OpenClosePush/PINChangePush strobes with a stable UserPINRead.
- Watches the safe's invalid indication and enforces a timed lockout after repeated failed attempts.

---
 rtl/pin_entry_frontend.sv | 105 ++++++++++
 tb/tb_pin_entry_frontend.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pin_entry_frontend.sv
// pin_entry_frontend: debounced button front end issuing PIN strobes with failed-attempt lockout
module pin_entry_frontend #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W = 21,
  parameter int RESULT_WINDOW = 8,
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       RawOpenClose,
  input  logic       RawPINChange,
  input  logic [3:0] RawPIN,
  input  logic       InvalidFlag,
  output logic [3:0] UserPINRead,
  output logic       OpenClosePush,
  output logic       PINChangePush,
  output logic       LockoutActive,
  output logic [2:0] AttemptCount
);
  typedef enum logic [1:0] {NORMAL, WAIT_RESULT, LOCKED} state_t;
  state_t state, state_n;
  logic [5:0] sync1, sync2;
  logic [1:0] db, db_d, armed, press, settle;
  logic [CNT_W-1:0] db_cnt [2];
  logic [CNT_W-1:0] win, win_n, lock, lock_n;
  logic [2:0] attempts_n, attempts_inc;
  logic [3:0] pin_n;
  logic inv_q, inv_hit, oc_n, pc_n;
  assign press = db & ~db_d & armed;
  assign inv_hit = InvalidFlag & (~inv_q | win == CNT_W'(RESULT_WINDOW - 1));
  assign attempts_inc = AttemptCount == 3'(MAX_ATTEMPTS) ? AttemptCount : AttemptCount + 3'd1;
  assign LockoutActive = state == LOCKED;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db <= '0;
      db_d <= '0;
      armed <= '0;
      settle <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
      inv_q <= 1'b0;
      state <= NORMAL;
      win <= '0;
      lock <= '0;
      AttemptCount <= '0;
      UserPINRead <= '0;
      OpenClosePush <= 1'b0;
      PINChangePush <= 1'b0;
    end else begin
      sync1 <= {RawPIN, RawPINChange, RawOpenClose};
      sync2 <= sync1;
      db_d <= db;
      inv_q <= InvalidFlag;
      settle <= settle[1] ? settle : settle + 2'd1;
      for (int i = 0; i < 2; i++) begin
        armed[i] <= armed[i] | (settle[1] & ~sync2[i] & ~db[i]);
        if (sync2[i] == db[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i] <= ~db[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + CNT_W'(1);
      end
      state <= state_n;
      win <= win_n;
      lock <= lock_n;
      AttemptCount <= attempts_n;
      UserPINRead <= pin_n;
      OpenClosePush <= oc_n;
      PINChangePush <= pc_n;
    end
  end
  always_comb begin
    state_n = state;
    win_n = win + CNT_W'(1);
    lock_n = lock + CNT_W'(1);
    attempts_n = AttemptCount;
    pin_n = UserPINRead;
    oc_n = 1'b0;
    pc_n = 1'b0;
    if (state == NORMAL) begin
      oc_n = press[0];
      pc_n = press[1] & ~press[0];
      win_n = '0;
      if (|press) begin
        pin_n = sync2[5:2];
        state_n = WAIT_RESULT;
      end
    end else if (state == WAIT_RESULT) begin
      if (inv_hit) begin
        attempts_n = attempts_inc;
        lock_n = '0;
        state_n = attempts_inc == 3'(MAX_ATTEMPTS) ? LOCKED : NORMAL;
      end else if (win == CNT_W'(RESULT_WINDOW - 1)) begin
        attempts_n = '0;
        state_n = NORMAL;
      end
    end else if (lock == CNT_W'(LOCKOUT_CYCLES - 1)) begin
      attempts_n = '0;
      state_n = NORMAL;
    end
  end
endmodule

// File: tb/tb_pin_entry_frontend.sv
// tb_pin_entry_frontend: directed checks of debounce, strobes, attempt counting and lockout
module tb_pin_entry_frontend;
  logic Clk = 1'b0, Reset = 1'b1;
  logic RawOpenClose = 1'b1, RawPINChange = 1'b1, InvalidFlag = 1'b0;
  logic [3:0] RawPIN = 4'h0;
  logic [3:0] UserPINRead;
  logic OpenClosePush, PINChangePush, LockoutActive;
  logic [2:0] AttemptCount;
  int total = 0, bad = 0, cyc = 0;
  int oc_cnt = 0, pc_cnt = 0, oc_cyc = 0, pc_cyc = 0;
  int t0, lock_hi;
  pin_entry_frontend #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8),
    .RESULT_WINDOW(8),
    .MAX_ATTEMPTS(3),
    .LOCKOUT_CYCLES(16)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .RawOpenClose(RawOpenClose),
    .RawPINChange(RawPINChange),
    .RawPIN(RawPIN),
    .InvalidFlag(InvalidFlag),
    .UserPINRead(UserPINRead),
    .OpenClosePush(OpenClosePush),
    .PINChangePush(PINChangePush),
    .LockoutActive(LockoutActive),
    .AttemptCount(AttemptCount)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    if (OpenClosePush === 1'b1) begin
      oc_cnt = oc_cnt + 1;
      oc_cyc = cyc;
    end
    if (PINChangePush === 1'b1) begin
      pc_cnt = pc_cnt + 1;
      pc_cyc = cyc;
    end
  end
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic do_attempt(input logic [2:0] k, input int exp_oc);
    RawPIN = {1'b0, k};
    RawOpenClose = 1'b1;
    repeat (9) tick();
    InvalidFlag = 1'b1;
    tick();
    InvalidFlag = 1'b0;
    check("attempt_count", AttemptCount, k);
    check("attempt_oc_cnt", oc_cnt, exp_oc);
    check("attempt_pin", UserPINRead, k);
    RawOpenClose = 1'b0;
  endtask
  initial begin
    repeat (3) tick();
    check("rst_pin", UserPINRead, 0);
    check("rst_oc", OpenClosePush, 0);
    check("rst_pc", PINChangePush, 0);
    check("rst_lock", LockoutActive, 0);
    check("rst_att", AttemptCount, 0);
    Reset = 1'b0;
    repeat (12) tick();
    check("held_no_oc", oc_cnt, 0);
    check("held_no_pc", pc_cnt, 0);
    RawOpenClose = 1'b0;
    RawPINChange = 1'b0;
    repeat (10) tick();
    check("release_no_strobe", oc_cnt + pc_cnt, 0);
    RawPIN = 4'hA;
    RawOpenClose = 1'b1;
    tick();
    RawOpenClose = 1'b0;
    tick();
    RawOpenClose = 1'b1;
    t0 = cyc;
    repeat (12) tick();
    check("bounce_oc_cnt", oc_cnt, 1);
    check("bounce_latency", oc_cyc - t0, 7);
    check("bounce_pin", UserPINRead, 4'hA);
    check("bounce_pc_cnt", pc_cnt, 0);
    RawOpenClose = 1'b0;
    repeat (12) tick();
    check("bounce_att", AttemptCount, 0);
    RawPIN = 4'h5;
    RawPINChange = 1'b1;
    t0 = cyc;
    repeat (10) tick();
    RawPIN = 4'h6;
    RawOpenClose = 1'b1;
    repeat (2) tick();
    check("valid_pc_cnt", pc_cnt, 1);
    check("valid_pc_latency", pc_cyc - t0, 7);
    check("valid_pin", UserPINRead, 4'h5);
    check("valid_att", AttemptCount, 0);
    RawPINChange = 1'b0;
    repeat (6) tick();
    check("post_window_oc_cnt", oc_cnt, 2);
    check("post_window_latency", oc_cyc - t0, 17);
    check("post_window_pin", UserPINRead, 4'h6);
    RawOpenClose = 1'b0;
    repeat (12) tick();
    check("post_window_att", AttemptCount, 0);
    do_attempt(3'd1, 3);
    repeat (10) tick();
    do_attempt(3'd2, 4);
    repeat (10) tick();
    do_attempt(3'd3, 5);
    lock_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        RawPIN = 4'hF;
        RawPINChange = 1'b1;
      end
      lock_hi = lock_hi + (LockoutActive === 1'b1 ? 1 : 0);
      tick();
    end
    check("lock_duration", lock_hi, 16);
    check("lock_pc_cnt", pc_cnt, 1);
    check("lock_pin", UserPINRead, 4'h3);
    check("lock_exit_att", AttemptCount, 0);
    check("lock_exit_active", LockoutActive, 0);
    RawPINChange = 1'b0;
    repeat (12) tick();
    check("held_exit_pc_cnt", pc_cnt, 1);
    RawPIN = 4'h3;
    RawOpenClose = 1'b1;
    RawPINChange = 1'b1;
    t0 = cyc;
    repeat (12) tick();
    check("simul_oc_cnt", oc_cnt, 6);
    check("simul_latency", oc_cyc - t0, 7);
    check("simul_pc_cnt", pc_cnt, 1);
    check("simul_pin", UserPINRead, 4'h3);
    RawOpenClose = 1'b0;
    RawPINChange = 1'b0;
    repeat (20) tick();
    do_attempt(3'd1, 7);
    repeat (10) tick();
    do_attempt(3'd2, 8);
    repeat (10) tick();
    do_attempt(3'd3, 9);
    check("relock_active", LockoutActive, 1);
    repeat (5) tick();
    Reset = 1'b1;
    tick();
    check("midlock_rst_active", LockoutActive, 0);
    check("midlock_rst_att", AttemptCount, 0);
    check("midlock_rst_pin", UserPINRead, 0);
    Reset = 1'b0;
    repeat (10) tick();
    RawPIN = 4'h9;
    RawOpenClose = 1'b1;
    t0 = cyc;
    repeat (12) tick();
    check("after_rst_oc_cnt", oc_cnt, 10);
    check("after_rst_latency", oc_cyc - t0, 7);
    check("after_rst_pin", UserPINRead, 4'h9);
    check("after_rst_active", LockoutActive, 0);
    RawOpenClose = 1'b0;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
